// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, drives the synchronous instruction SRAM (1-cycle read latency),
// buffers one returned word across a stall, tracks branch delay slots and
// tags misaligned fetches as AdEL.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        id_is_branch,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_wen,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_adel,
   output logic        id_in_ds
);

   typedef enum logic {RUN, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_v_q, req_v_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        req_adel_q, req_adel_d;
   logic [31:0] buf_q, buf_d;
   logic        buf_v_q, buf_v_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_adel_q, id_adel_d;
   logic        id_in_ds_q, id_in_ds_d;

   logic [31:0] faddr;
   logic        issue;

   // Fetch address select and SRAM request; flush also overrides stall here
   // so the restart address is actually read in the flush cycle.
   always_comb begin
      if (flush) begin
         faddr = flush_pc;
      end else if (br_taken && !stall) begin
         faddr = br_target;
      end else begin
         faddr = pc_q;
      end
      issue           = !stall || flush;
      inst_sram_addr  = faddr;
      inst_sram_en    = resetn && issue && (faddr[1:0] == 2'b00);
      inst_sram_wen   = '0;
      inst_sram_wdata = '0;
   end

   // Next-state logic: request tracking, stall buffer FSM and IF/ID advance.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_v_d    = req_v_q;
      req_pc_d   = req_pc_q;
      req_adel_d = req_adel_q;
      buf_d      = buf_q;
      buf_v_d    = buf_v_q;
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_adel_d  = id_adel_q;
      id_in_ds_d = id_in_ds_q;

      if (issue) begin
         pc_d       = faddr + 32'd4;
         req_v_d    = 1'b1;
         req_pc_d   = faddr;
         req_adel_d = |faddr[1:0];
      end

      if (flush) begin
         id_valid_d = 1'b0;
         id_adel_d  = 1'b0;
         id_in_ds_d = 1'b0;
         buf_v_d    = 1'b0;
         state_d    = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (!stall) begin
                  id_valid_d = req_v_q;
                  id_pc_d    = req_pc_q;
                  id_inst_d  = req_adel_q ? NOP_INST : inst_sram_rdata;
                  id_adel_d  = req_v_q && req_adel_q;
                  id_in_ds_d = id_is_branch && id_valid_q;
               end else if (req_v_q) begin
                  buf_d   = inst_sram_rdata;
                  buf_v_d = 1'b1;
                  req_v_d = 1'b0;
                  state_d = HOLD;
               end
            end
            HOLD: begin
               // req_pc/req_adel still describe the buffered word here;
               // the new request overwrites them only at this edge.
               if (!stall) begin
                  id_valid_d = buf_v_q;
                  id_pc_d    = req_pc_q;
                  id_inst_d  = req_adel_q ? NOP_INST : buf_q;
                  id_adel_d  = req_adel_q;
                  id_in_ds_d = id_is_branch && id_valid_q;
                  buf_v_d    = 1'b0;
                  state_d    = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         req_v_q    <= 1'b0;
         req_pc_q   <= '0;
         req_adel_q <= 1'b0;
         buf_q      <= '0;
         buf_v_q    <= 1'b0;
         id_valid_q <= 1'b0;
         id_pc_q    <= '0;
         id_inst_q  <= NOP_INST;
         id_adel_q  <= 1'b0;
         id_in_ds_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_v_q    <= req_v_d;
         req_pc_q   <= req_pc_d;
         req_adel_q <= req_adel_d;
         buf_q      <= buf_d;
         buf_v_q    <= buf_v_d;
         id_valid_q <= id_valid_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_adel_q  <= id_adel_d;
         id_in_ds_q <= id_in_ds_d;
      end
   end

   // IF/ID outputs; a bubble or an AdEL-tagged fetch presents the NOP word.
   always_comb begin
      id_valid = id_valid_q;
      id_pc    = id_pc_q;
      id_adel  = id_adel_q;
      id_in_ds = id_in_ds_q;
      id_inst  = (id_valid_q && !id_adel_q) ? id_inst_q : NOP_INST;
   end

endmodule
